// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the ALU control decoder, the execution stage and its consumer.
// Master drives requests and out_ready; slave (the execution stage) drives results and status.
interface alu_exec_unit_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, alu_sel, op_a, op_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow, busy
    );

    modport slave (
        input  in_valid, alu_sel, op_a, op_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// 16-bit execution stage: add/sub/and/or/slt in one cycle, sll/srl one bit per cycle (N+1 cycles).
// Results hold while out_valid && !out_ready; in_ready depends only on state and out_ready.
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_unit_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    logic [WIDTH-1:0] sum, diff, alu_res, work_shift;
    logic             add_ovf, sub_ovf, alu_ovf;
    logic             is_shift, start_shift, accept;
    logic             in_ready, out_valid, busy;

    // Single-cycle datapath; shamt==0 shifts collapse to a pass-through of op_b.
    always_comb begin
        sum     = bus.op_a + bus.op_b;
        diff    = bus.op_a - bus.op_b;
        add_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
        sub_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_sel)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            OP_AND:  alu_res = bus.op_a & bus.op_b;
            OP_OR:   alu_res = bus.op_a | bus.op_b;
            OP_SLL,
            OP_SRL:  alu_res = bus.op_b;
            default: alu_res = '0;
        endcase
        is_shift    = (bus.alu_sel == OP_SLL) || (bus.alu_sel == OP_SRL);
        start_shift = is_shift && (bus.shamt != '0);
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        work_shift = left_q ? (work_q << 1) : (work_q >> 1);
        in_ready   = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        out_valid  = (state_q == DONE);
        busy       = (state_q == SHIFT);
        accept     = bus.in_valid && in_ready;

        case (state_q)
            SHIFT: begin
                work_d = work_shift;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_d   = work_shift;
                    zero_d  = (work_shift == '0);
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // An accept in DONE overrides the return to IDLE so handoff and load share one edge.
        if (accept) begin
            if (start_shift) begin
                work_d  = bus.op_b;
                cnt_d   = bus.shamt;
                left_d  = (bus.alu_sel == OP_SLL);
                state_d = SHIFT;
            end else begin
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                ovf_d   = alu_ovf;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: per-feature tasks with hand-computed expected values.
module tb_alu_exec_unit;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.shamt    = sh;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_sel   = 3'b000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.shamt     = '0;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", bus.result); end
        checks++; if (bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags got z=%b ov=%b want z=0 ov=0", bus.zero, bus.overflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_cycle();
        vec_t v [12] = '{
            '{3'b000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b0, 1'b1},
            '{3'b100, 16'h0005, 16'h0005, 4'd0, 16'h0000, 1'b1, 1'b0},
            '{3'b011, 16'h8000, 16'h7FFF, 4'd0, 16'h0001, 1'b0, 1'b0},
            '{3'b100, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 1'b0, 1'b1},
            '{3'b011, 16'h7FFF, 16'h8000, 4'd0, 16'h0000, 1'b1, 1'b0},
            '{3'b011, 16'h0003, 16'h0005, 4'd0, 16'h0001, 1'b0, 1'b0},
            '{3'b001, 16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 1'b0, 1'b0},
            '{3'b010, 16'h00F0, 16'h0F00, 4'd0, 16'h0FF0, 1'b0, 1'b0},
            '{3'b000, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 1'b0},
            '{3'b100, 16'h7FFF, 16'hFFFF, 4'd0, 16'h8000, 1'b0, 1'b1},
            '{3'b111, 16'h1234, 16'h5678, 4'd3, 16'h0000, 1'b1, 1'b0},
            '{3'b101, 16'h1111, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(v[i].sel, v[i].a, v[i].b, v[i].sh);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_out_valid got %b want 1", i, bus.out_valid); end
            checks++; if (bus.result !== v[i].res) begin errors++; $display("FAIL op%0d_result got %h want %h", i, bus.result, v[i].res); end
            checks++; if (bus.zero !== v[i].z || bus.overflow !== v[i].ov) begin
                errors++; $display("FAIL op%0d_flags got z=%b ov=%b want z=%b ov=%b", i, bus.zero, bus.overflow, v[i].z, v[i].ov);
            end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_idle got out_valid=%b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_shift();
        vec_t v [6] = '{
            '{3'b101, 16'hFFFF, 16'h0003, 4'd4,  16'h0030, 1'b0, 1'b0},
            '{3'b110, 16'hFFFF, 16'hF000, 4'd12, 16'h000F, 1'b0, 1'b0},
            '{3'b110, 16'hFFFF, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0},
            '{3'b101, 16'hFFFF, 16'h00FF, 4'd8,  16'hFF00, 1'b0, 1'b0},
            '{3'b101, 16'hFFFF, 16'h8001, 4'd1,  16'h0002, 1'b0, 1'b0},
            '{3'b110, 16'hFFFF, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b0}
        };
        int n;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(v[i].sel, v[i].a, v[i].b, v[i].sh);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 40) begin
                checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL sh%0d_busy cycle %0d got busy=%b in_ready=%b want 1/0", i, n, bus.busy, bus.in_ready);
                end
                // Fields changing while not ready must be ignored.
                bus.op_b    = ~bus.op_b;
                bus.shamt   = bus.shamt + 4'd1;
                bus.alu_sel = 3'b000;
                tick();
                n++;
            end
            checks++; if (n !== int'(v[i].sh)) begin errors++; $display("FAIL sh%0d_latency got %0d want %0d", i, n, v[i].sh); end
            checks++; if (bus.result !== v[i].res) begin errors++; $display("FAIL sh%0d_result got %h want %h", i, bus.result, v[i].res); end
            checks++; if (bus.zero !== v[i].z || bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL sh%0d_flags got z=%b ov=%b busy=%b want z=%b ov=0 busy=0", i, bus.zero, bus.overflow, bus.busy, v[i].z);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(3'b010, 16'h00F0, 16'h0F00, 4'd0);
        bus.in_valid = 1'b1;
        bus.alu_sel  = 3'b001;
        bus.op_a     = 16'hFF00;
        bus.op_b     = 16'h0FF0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp%0d_hs got out_valid=%b in_ready=%b want 1/0", i, bus.out_valid, bus.in_ready);
            end
            checks++; if (bus.result !== 16'h0FF0 || bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
                errors++; $display("FAIL bp%0d_hold got %h z=%b ov=%b want 0ff0 z=0 ov=0", i, bus.result, bus.zero, bus.overflow);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_follow got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0F00) begin
            errors++; $display("FAIL bp_handoff got out_valid=%b result=%h want 1 0f00", bus.out_valid, bus.result);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        bus.out_ready = 1'b1;
        issue(3'b101, 16'h0000, 16'h0001, 4'd8);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state got out_valid=%b busy=%b in_ready=%b want 0/0/1", bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++; if (bus.result !== 16'h0000 || bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got %h z=%b ov=%b want 0000 z=0 ov=0", bus.result, bus.zero, bus.overflow);
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result got out_valid seen=%b want 0", seen); end
        issue(3'b000, 16'h0010, 16'h0020, 4'd0);
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0030) begin
            errors++; $display("FAIL rst_mid_recover got out_valid=%b result=%h want 1 0030", bus.out_valid, bus.result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a   [4] = '{16'h0001, 16'h1000, 16'hFFFF, 16'h8000};
        logic [15:0] b   [4] = '{16'h0002, 16'h0234, 16'h0001, 16'h8000};
        logic [15:0] exp [4] = '{16'h0003, 16'h1234, 16'h0000, 16'h0000};
        logic        ov  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        bus.alu_sel   = 3'b000;
        bus.shamt     = '0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = a[k];
            bus.op_b     = b[k];
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.result !== exp[k] || bus.overflow !== ov[k]) begin
                errors++; $display("FAIL b2b%0d got v=%b res=%h ov=%b want v=1 res=%h ov=%b", k, bus.out_valid, bus.result, bus.overflow, exp[k], ov[k]);
            end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready got %b want 1", k, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got out_valid=%b want 0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
